// File: rtl/i2c_write_arbiter_if.sv
// rtl/i2c_write_arbiter_if.sv - requester handshakes and I2C master operand bus
// The arbiter takes the slave view; the requesters and the I2C master sit on the master view.
interface i2c_write_arbiter_if;
  logic       i_req0_valid;
  logic [6:0] i_req0_dev;
  logic [7:0] i_req0_addr;
  logic [7:0] i_req0_data;
  logic       o_req0_ready;

  logic       i_req1_valid;
  logic [6:0] i_req1_dev;
  logic [7:0] i_req1_addr;
  logic [7:0] i_req1_data;
  logic       o_req1_ready;

  logic [1:0] o_done;
  logic [1:0] o_timeout;
  logic       o_busy;

  logic       o_i2c_en;
  logic [6:0] o_device_addr;
  logic [7:0] o_data_addr;
  logic [7:0] o_write_data;
  logic       i_done_flag;

  modport slave (
    input  i_req0_valid, i_req0_dev, i_req0_addr, i_req0_data,
    input  i_req1_valid, i_req1_dev, i_req1_addr, i_req1_data,
    input  i_done_flag,
    output o_req0_ready, o_req1_ready,
    output o_done, o_timeout, o_busy,
    output o_i2c_en, o_device_addr, o_data_addr, o_write_data
  );

  modport master (
    output i_req0_valid, i_req0_dev, i_req0_addr, i_req0_data,
    output i_req1_valid, i_req1_dev, i_req1_addr, i_req1_data,
    output i_done_flag,
    input  o_req0_ready, o_req1_ready,
    input  o_done, o_timeout, o_busy,
    input  o_i2c_en, o_device_addr, o_data_addr, o_write_data
  );
endinterface

// File: rtl/i2c_write_arbiter.sv
// rtl/i2c_write_arbiter.sv - round-robin arbiter of two single-byte I2C write requesters
// Holds the master enable until done or timeout, then enforces an idle gap before the next grant.
module i2c_write_arbiter #(
  parameter int GAP_CYCLES     = 1000,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  i2c_write_arbiter_if.slave bus
);

  localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int TO_EFF  = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_EFF - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_EFF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic [6:0]       dev_q, dev_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       to_q, to_d;

  logic is_idle;
  logic any_valid;
  logic sel;
  logic owner_onehot_hi;

  assign is_idle   = (state_q == ST_IDLE);
  assign any_valid = bus.i_req0_valid | bus.i_req1_valid;

  // Contention goes to whoever was not served last; otherwise the lone requester wins.
  always_comb begin
    sel = 1'b0;
    if (bus.i_req0_valid && bus.i_req1_valid) begin
      sel = ~last_q;
    end else if (bus.i_req1_valid) begin
      sel = 1'b1;
    end
  end

  assign bus.o_req0_ready = is_idle && bus.i_req0_valid && !sel;
  assign bus.o_req1_ready = is_idle && bus.i_req1_valid && sel;

  assign owner_onehot_hi = owner_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    dev_d   = dev_q;
    addr_d  = addr_q;
    data_d  = data_q;
    owner_d = owner_q;
    last_d  = last_q;
    done_d  = 2'b00;
    to_d    = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          state_d = ST_RUN;
          en_d    = 1'b1;
          owner_d = sel;
          last_d  = sel;
          cnt_d   = '0;
          if (sel) begin
            dev_d  = bus.i_req1_dev;
            addr_d = bus.i_req1_addr;
            data_d = bus.i_req1_data;
          end else begin
            dev_d  = bus.i_req0_dev;
            addr_d = bus.i_req0_addr;
            data_d = bus.i_req0_data;
          end
        end
      end

      ST_RUN: begin
        // Completion is checked first so a done on the final timeout cycle still counts as done.
        if (bus.i_done_flag) begin
          state_d = ST_GAP;
          en_d    = 1'b0;
          cnt_d   = '0;
          done_d  = owner_onehot_hi ? 2'b10 : 2'b01;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_GAP;
          en_d    = 1'b0;
          cnt_d   = '0;
          to_d    = owner_onehot_hi ? 2'b10 : 2'b01;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      dev_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      done_q  <= 2'b00;
      to_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      dev_q   <= dev_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      done_q  <= done_d;
      to_q    <= to_d;
    end
  end

  assign bus.o_i2c_en      = en_q;
  assign bus.o_device_addr = dev_q;
  assign bus.o_data_addr   = addr_q;
  assign bus.o_write_data  = data_q;
  assign bus.o_done        = done_q;
  assign bus.o_timeout     = to_q;
  assign bus.o_busy        = !is_idle;

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// tb/tb_i2c_write_arbiter.sv - bench for i2c_write_arbiter with requester queues and a master model
module tb_i2c_write_arbiter;

  localparam int G = 4;
  localparam int T = 16;

  typedef struct packed {
    logic [6:0] dev;
    logic [7:0] addr;
    logic [7:0] data;
  } item_t;

  logic clk = 1'b0;
  logic rst_n;

  i2c_write_arbiter_if bus ();

  i2c_write_arbiter #(
    .GAP_CYCLES    (G),
    .TIMEOUT_CYCLES(T),
    .CNT_W         (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  item_t q0[$];
  item_t q1[$];
  int    grant_log[$];

  int n = 0;
  int fixed_lat = 0;
  int lat_cur = 0;
  int en_cnt = 0;
  bit drop_en = 0;
  bit noise_en = 0;

  bit en_prev = 0;
  int run_len = 0;
  int last_gap = 0;
  int last_en_len = 0;

  bit         mdl_has = 0;
  int         mdl_start = 0;
  int         mdl_end = 0;
  bit         mdl_isdone = 0;
  bit         mdl_owner = 0;
  bit         mdl_last = 1;
  logic [6:0] mdl_dev = '0;
  logic [7:0] mdl_addr = '0;
  logic [7:0] mdl_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  function automatic bit idle_ok(input int e);
    return !mdl_has || (e >= mdl_end + G + 1);
  endfunction

  function automatic item_t rand_item();
    item_t it;
    it.dev  = 7'($urandom);
    it.addr = 8'($urandom);
    it.data = 8'($urandom);
    return it;
  endfunction

  function automatic item_t mk(input logic [6:0] d, input logic [7:0] a, input logic [7:0] w);
    item_t it;
    it.dev = d; it.addr = a; it.data = w;
    return it;
  endfunction

  task automatic model_reset();
    mdl_has  = 0;
    mdl_last = 1;
    mdl_dev  = '0;
    mdl_addr = '0;
    mdl_data = '0;
  endtask

  task automatic model_accept(input int e, input bit k, input item_t it);
    mdl_has    = 1;
    mdl_start  = e;
    lat_cur    = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 20));
    mdl_end    = e + ((lat_cur < T) ? lat_cur : T);
    mdl_isdone = (lat_cur <= T);
    mdl_owner  = k;
    mdl_last   = k;
    mdl_dev    = it.dev;
    mdl_addr   = it.addr;
    mdl_data   = it.data;
  endtask

  task automatic check_outputs(input int m);
    logic [1:0] oh;
    bit act;
    oh  = mdl_owner ? 2'b10 : 2'b01;
    act = mdl_has && (m >= mdl_start) && (m < mdl_end);
    chk("i2c_en", 32'(bus.o_i2c_en), 32'(act));
    chk("done", 32'(bus.o_done), (mdl_has && m == mdl_end && mdl_isdone) ? 32'(oh) : 32'd0);
    chk("timeout", 32'(bus.o_timeout), (mdl_has && m == mdl_end && !mdl_isdone) ? 32'(oh) : 32'd0);
    chk("busy", 32'(bus.o_busy), 32'(mdl_has && m >= mdl_start && m < mdl_end + G));
    chk("device_addr", 32'(bus.o_device_addr), 32'(mdl_dev));
    chk("data_addr", 32'(bus.o_data_addr), 32'(mdl_addr));
    chk("write_data", 32'(bus.o_write_data), 32'(mdl_data));
  endtask

  task automatic cyc();
    logic [1:0] vv, exp_rdy;
    bit ks;
    @(negedge clk);
    check_outputs(n - 1);

    if (bus.o_i2c_en != en_prev) begin
      if (bus.o_i2c_en) last_gap = run_len;
      else last_en_len = run_len;
      run_len = 1;
    end else begin
      run_len++;
    end
    en_prev = bus.o_i2c_en;

    if (bus.o_i2c_en) begin
      en_cnt++;
      bus.i_done_flag = (en_cnt == lat_cur);
    end else begin
      en_cnt = 0;
      bus.i_done_flag = noise_en && ($urandom_range(0, 3) == 0);
    end

    bus.i_req0_valid = (q0.size() > 0) && (!drop_en || $urandom_range(0, 3) != 0);
    bus.i_req1_valid = (q1.size() > 0) && (!drop_en || $urandom_range(0, 3) != 0);
    if (q0.size() > 0) {bus.i_req0_dev, bus.i_req0_addr, bus.i_req0_data} = q0[0];
    if (q1.size() > 0) {bus.i_req1_dev, bus.i_req1_addr, bus.i_req1_data} = q1[0];

    #3;
    vv = {bus.i_req1_valid, bus.i_req0_valid};
    exp_rdy = 2'b00;
    ks = 0;
    if (idle_ok(n) && vv != 2'b00) begin
      ks = (vv == 2'b11) ? !mdl_last : vv[1];
      exp_rdy = ks ? 2'b10 : 2'b01;
    end
    chk("ready", 32'({bus.o_req1_ready, bus.o_req0_ready}), 32'(exp_rdy));
    if (exp_rdy != 2'b00) model_accept(n, ks, ks ? q1[0] : q0[0]);

    if (bus.i_req0_valid && bus.o_req0_ready) begin
      void'(q0.pop_front());
      grant_log.push_back(0);
    end
    if (bus.i_req1_valid && bus.o_req1_ready) begin
      void'(q1.pop_front());
      grant_log.push_back(1);
    end
    n++;
  endtask

  task automatic run_quiet(input string tag, input int budget);
    int k;
    k = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && idle_ok(n)) && k < budget) begin
      cyc();
      k++;
    end
    chk({"drain_", tag}, 32'(k < budget), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_en"}, 32'(bus.o_i2c_en), 32'd0);
    chk({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.o_done), 32'd0);
    chk({tag, "_timeout"}, 32'(bus.o_timeout), 32'd0);
    chk({tag, "_ops"}, 32'({bus.o_device_addr, bus.o_data_addr, bus.o_write_data}), 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.i_req0_valid = 1'b0;
    bus.i_req1_valid = 1'b0;
    bus.i_done_flag  = 1'b0;
    #1;
    check_reset_values("async_rst");
    repeat (cycles) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    n++;
    model_reset();
    en_cnt  = 0;
    en_prev = 0;
    run_len = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at edge %0d", n);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.i_req0_valid = 0; bus.i_req0_dev = 0; bus.i_req0_addr = 0; bus.i_req0_data = 0;
    bus.i_req1_valid = 0; bus.i_req1_dev = 0; bus.i_req1_addr = 0; bus.i_req1_data = 0;
    bus.i_done_flag = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    n = 1;

    // Single write from requester 0, done after 10 enabled cycles.
    fixed_lat = 10;
    q0.push_back(mk(7'h50, 8'h12, 8'hA5));
    run_quiet("single", 200);
    chk("single_en_len", 32'(last_en_len), 32'd10);

    // Simultaneous requests right after reset: requester 0 first, 5-cycle enable gap.
    do_reset(2);
    fixed_lat = 6;
    grant_log.delete();
    q0.push_back(mk(7'h50, 8'h01, 8'h11));
    q1.push_back(mk(7'h51, 8'h02, 8'h22));
    run_quiet("both", 200);
    chk("both_gap", 32'(last_gap), 32'(G + 1));
    chk("both_n", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) chk("both_order", 32'({grant_log[0], grant_log[1]}), 32'({32'd0, 32'd1}));

    // Continuous contention alternates 0,1,0,1.
    fixed_lat = 3;
    grant_log.delete();
    for (int i = 0; i < 2; i++) begin
      q0.push_back(rand_item());
      q1.push_back(rand_item());
    end
    run_quiet("rr", 300);
    chk("rr_n", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < grant_log.size() && i < 4; i++) chk("rr_order", 32'(grant_log[i]), 32'(i % 2));

    // Master never finishes: timeout after exactly T enabled cycles, then next grant proceeds.
    fixed_lat = 1000;
    q0.push_back(rand_item());
    q1.push_back(rand_item());
    run_quiet("timeout", 300);
    chk("timeout_en_len", 32'(last_en_len), 32'(T));

    // Done coincides with the last timeout cycle: done wins.
    fixed_lat = T;
    q1.push_back(rand_item());
    run_quiet("tie", 200);
    chk("tie_en_len", 32'(last_en_len), 32'(T));

    // Randomized traffic with dropping valids, random latencies and stray done flags.
    fixed_lat = 0;
    drop_en = 1;
    noise_en = 1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) q0.push_back(rand_item());
      else q1.push_back(rand_item());
      repeat ($urandom_range(0, 8)) cyc();
    end
    run_quiet("random", 4000);
    drop_en = 0;
    noise_en = 0;

    // Reset in the middle of a requester 1 transaction with requester 0 waiting.
    fixed_lat = 1000;
    q1.push_back(rand_item());
    begin
      int k;
      k = 0;
      while (!bus.o_i2c_en && k < 40) begin
        cyc();
        k++;
      end
      chk("rst_grant_seen", 32'(bus.o_i2c_en), 32'd1);
    end
    q0.push_back(mk(7'h2A, 8'h33, 8'h44));
    repeat (10) cyc();
    do_reset(3);
    fixed_lat = 5;
    grant_log.delete();
    q1.push_back(mk(7'h3B, 8'h55, 8'h66));
    run_quiet("after_rst", 300);
    chk("after_rst_n", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() > 0) chk("after_rst_first", 32'(grant_log[0]), 32'd0);
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
